alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base integer ops plus radix-2 iterative multiply/divide.
// Results and compare flags are held until the consumer handshakes.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             equ_o,
  output logic             lt_o,
  output logic             ltu_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             accept_s;

  logic [2:0]       mop_r;
  logic [WIDTH-1:0] in0_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] mcand_r;
  logic             neg_r;
  logic             rneg_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] out_r;
  logic             equ_r;
  logic             lt_r;
  logic             ltu_r;

  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_diff_s;
  logic [WIDTH-1:0]   acc_nx_s;
  logic [WIDTH-1:0]   lo_nx_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic               div_zero_s;
  logic [WIDTH-1:0]   res_s;

  function automatic logic [WIDTH-1:0] base_op(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] r;
    sh = b[SHW-1:0];
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0111: r = a & b;
      4'b0110: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b0001: r = a << sh;
      4'b1101: r = $signed(a) >>> sh;
      4'b0010: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // MULH, MULHSU, DIV and REM treat operand A as signed.
  function automatic logic a_is_signed(input logic [2:0] mop);
    logic r;
    case (mop)
      3'b001, 3'b010, 3'b100, 3'b110: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // MULH, DIV and REM treat operand B as signed.
  function automatic logic b_is_signed(input logic [2:0] mop);
    logic r;
    case (mop)
      3'b001, 3'b100, 3'b110: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  assign accept_s = valid_i & (state_r == IDLE) & ~flush_i;
  assign ready_o  = (state_r == IDLE);
  assign valid_o  = (state_r == DONE);
  assign out_o    = out_r;
  assign equ_o    = equ_r;
  assign lt_o     = lt_r;
  assign ltu_o    = ltu_r;

  // Operand magnitudes and signs for the iterative engine
  always_comb begin
    a_neg_s = a_is_signed(op_i[2:0]) & in0_i[WIDTH-1];
    b_neg_s = b_is_signed(op_i[2:0]) & in1_i[WIDTH-1];
    a_mag_s = a_neg_s ? -in0_i : in0_i;
    b_mag_s = b_neg_s ? -in1_i : in1_i;
  end

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    acc_nx_s   = acc_r;
    lo_nx_s    = lo_r;
    mul_sum_s  = {1'b0, acc_r} + (lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    div_diff_s = {acc_r, lo_r[WIDTH-1]} - {1'b0, mcand_r};
    if (mop_r[2]) begin
      // A clear top bit means the trial subtraction did not borrow.
      if (!div_diff_s[WIDTH]) begin
        acc_nx_s = div_diff_s[WIDTH-1:0];
        lo_nx_s  = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = {acc_r[WIDTH-2:0], lo_r[WIDTH-1]};
        lo_nx_s  = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx_s = mul_sum_s[WIDTH:1];
      lo_nx_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Final sign correction and special-case selection after the last step
  always_comb begin
    prod_s     = {acc_nx_s, lo_nx_s};
    prod_fix_s = neg_r ? -prod_s : prod_s;
    quo_fix_s  = neg_r ? -lo_nx_s : lo_nx_s;
    rem_fix_s  = rneg_r ? -acc_nx_s : acc_nx_s;
    div_zero_s = (mcand_r == {WIDTH{1'b0}});
    res_s      = {WIDTH{1'b0}};
    case (mop_r)
      3'b000:                 res_s = prod_fix_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         res_s = div_zero_s ? {WIDTH{1'b1}} : quo_fix_s;
      3'b110, 3'b111:         res_s = div_zero_s ? in0_r : rem_fix_s;
      default:                res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_s = state_r;
    if (flush_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = valid_i ? (op_i[4] ? BUSY : DONE) : IDLE;
        BUSY:    state_s = (cnt_r == CNT_LAST) ? DONE : BUSY;
        DONE:    state_s = ready_i ? IDLE : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration registers and result/flag registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mop_r   <= 3'b000;
      in0_r   <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
      rneg_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
      out_r   <= {WIDTH{1'b0}};
      equ_r   <= 1'b0;
      lt_r    <= 1'b0;
      ltu_r   <= 1'b0;
    end else if (flush_i) begin
      cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mop_r <= op_i[2:0];
            in0_r <= in0_i;
            equ_r <= (in0_i == in1_i);
            lt_r  <= ($signed(in0_i) < $signed(in1_i));
            ltu_r <= (in0_i < in1_i);
            if (op_i[4]) begin
              acc_r   <= {WIDTH{1'b0}};
              lo_r    <= op_i[2] ? a_mag_s : b_mag_s;
              mcand_r <= op_i[2] ? b_mag_s : a_mag_s;
              neg_r   <= a_neg_s ^ b_neg_s;
              rneg_r  <= a_neg_s;
              cnt_r   <= CNT_LOAD;
            end else begin
              out_r <= base_op(op_i[3:0], in0_i, in1_i);
            end
          end
        end
        BUSY: begin
          acc_r <= acc_nx_s;
          lo_r  <= lo_nx_s;
          cnt_r <= cnt_r - CNT_LAST;
          if (cnt_r == CNT_LAST) begin
            out_r <= res_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks of alu_mc against a 64-bit arithmetic reference model.
module tb_alu_mc;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  op_i;
  logic [31:0] in0_i;
  logic [31:0] in1_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] out_o;
  logic        equ_o;
  logic        lt_o;
  logic        ltu_o;

  int vectors;
  int miscompares;

  alu_mc #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .in0_i   (in0_i),
    .in1_i   (in1_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .out_o   (out_o),
    .equ_o   (equ_o),
    .lt_o    (lt_o),
    .ltu_o   (ltu_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition of each opcode.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    if (op[4]) begin
      case (op[2:0])
        3'd0: p = ua * ub;
        3'd1: p = (sa * sb) >> 32;
        3'd2: p = (sa * longint'(ub)) >> 32;
        3'd3: p = (ua * ub) >> 32;
        3'd4: begin
          if (b == 32'd0) p = 64'hFFFF_FFFF;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, a};
          else p = sa / sb;
        end
        3'd5: begin
          if (b == 32'd0) p = 64'hFFFF_FFFF;
          else p = ua / ub;
        end
        3'd6: begin
          if (b == 32'd0) p = {32'd0, a};
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'd0;
          else p = sa % sb;
        end
        default: begin
          if (b == 32'd0) p = {32'd0, a};
          else p = ua % ub;
        end
      endcase
    end else begin
      case (op[3:0])
        4'b0000: p = ua + ub;
        4'b1000: p = ua - ub;
        4'b0111: p = ua & ub;
        4'b0110: p = ua | ub;
        4'b0100: p = ua ^ ub;
        4'b0101: p = ua >> b[4:0];
        4'b0001: p = ua << b[4:0];
        4'b1101: p = sa >>> b[4:0];
        4'b0010: p = (sa < sb) ? 64'd1 : 64'd0;
        4'b0011: p = (ua < ub) ? 64'd1 : 64'd0;
        default: p = 64'd0;
      endcase
    end
    return p[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 40));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One full transaction: request, wait for result, check, optional hold, handshake.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit kuse, input logic [31:0] kexp);
    logic [31:0] exp_out;
    int          lat;
    int          explat;
    exp_out = model(op, a, b);
    explat  = op[4] ? 33 : 1;
    chk({tag, "/ready"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; op_i = op; in0_i = a; in1_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0; op_i = 5'($urandom); in0_i = $urandom; in1_i = $urandom;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(explat));
    chk({tag, "/out"}, out_o, exp_out);
    chk({tag, "/equ"}, 32'(equ_o), 32'(a == b));
    chk({tag, "/lt"}, 32'(lt_o), 32'($signed(a) < $signed(b)));
    chk({tag, "/ltu"}, 32'(ltu_o), 32'(a < b));
    if (kuse) chk({tag, "/vector"}, out_o, kexp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      chk({tag, "/hold_out"}, out_o, exp_out);
      chk({tag, "/hold_valid"}, 32'(valid_o), 32'd1);
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk({tag, "/back_idle"}, 32'({ready_o, valid_o}), 32'd2);
  endtask

  initial begin
    logic [3:0]  base_ops [10];
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    int          seen_valid;

    vectors     = 0;
    miscompares = 0;
    base_ops = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                 4'b0101, 4'b0001, 4'b1101, 4'b0010, 4'b0011};
    rst_i = 1'b0; valid_i = 1'b0; op_i = 5'd0; in0_i = 32'd0; in1_i = 32'd0;
    flush_i = 1'b0; ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset/ready", 32'(ready_o), 32'd1);
    chk("reset/valid", 32'(valid_o), 32'd0);
    chk("reset/out", out_o, 32'd0);
    chk("reset/flags", 32'({equ_o, lt_o, ltu_o}), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Multiply corner vectors
    do_op("mul_ones", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0001);
    do_op("mulhu_ones", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE);
    do_op("mulh_ones", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000);

    // Divide overflow and divide by zero
    do_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000);
    do_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000);
    do_op("divu_zero", 5'b10101, 32'd7, 32'd0, 0, 1'b1, 32'hFFFF_FFFF);
    do_op("remu_zero", 5'b10111, 32'd7, 32'd0, 0, 1'b1, 32'd7);
    do_op("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFD);
    do_op("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFF);
    do_op("rem_zero_s", 5'b10110, 32'hFFFF_FFF9, 32'd0, 0, 1'b1, 32'hFFFF_FFF9);

    // Shift amount truncation and signed compare
    do_op("sra_trunc", 5'b01101, 32'h8000_0000, 32'h0000_0021, 0, 1'b1, 32'hC000_0000);
    do_op("slt_neg", 5'b00010, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'd1);
    do_op("undef_op", 5'b01111, 32'd4, 32'd4, 0, 1'b1, 32'd0);

    // Result held while the consumer stalls; requests during DONE are ignored
    valid_i = 1'b1; op_i = 5'b00000; in0_i = 32'd5; in1_i = 32'd3;
    @(posedge clk_i); #1;
    op_i = 5'b01000; in0_i = 32'd1; in1_i = 32'd2;
    for (int i = 0; i < 10; i++) begin
      chk("stall/valid", 32'(valid_o), 32'd1);
      chk("stall/out", out_o, 32'd8);
      chk("stall/ready", 32'(ready_o), 32'd0);
      chk("stall/lt", 32'(lt_o), 32'd0);
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("stall/no_bypass", 32'({ready_o, valid_o}), 32'd2);
    ready_i = 1'b0; valid_i = 1'b0;

    // Asynchronous reset in the middle of a divide
    valid_i = 1'b1; op_i = 5'b10101; in0_i = $urandom; in1_i = 32'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst/ready", 32'(ready_o), 32'd1);
    chk("arst/valid", 32'(valid_o), 32'd0);
    chk("arst/out", out_o, 32'd0);
    chk("arst/flags", 32'({equ_o, lt_o, ltu_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1) seen_valid++;
    end
    chk("arst/no_result", 32'(seen_valid), 32'd0);
    do_op("arst/add", 5'b00000, 32'd1, 32'd1, 0, 1'b1, 32'd2);

    // Flush during a multiply
    valid_i = 1'b1; op_i = 5'b10000; in0_i = $urandom; in1_i = $urandom;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush/idle", 32'({ready_o, valid_o}), 32'd2);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1) seen_valid++;
    end
    chk("flush/no_result", 32'(seen_valid), 32'd0);
    do_op("flush/mulhu", 5'b10011, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 32'd0);

    // Flush in DONE wins over ready_i and over a simultaneous request
    valid_i = 1'b1; op_i = 5'b00000; in0_i = 32'd9; in1_i = 32'd9;
    @(posedge clk_i); #1;
    chk("flush_done/valid", 32'(valid_o), 32'd1);
    flush_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("flush_done/idle", 32'({ready_o, valid_o}), 32'd2);
    @(posedge clk_i); #1;
    chk("flush_idle/no_accept", 32'({ready_o, valid_o}), 32'd2);
    flush_i = 1'b0; ready_i = 1'b0; valid_i = 1'b0;
    @(posedge clk_i); #1;

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 10) rop = {1'b0, base_ops[sel]};
      else if (sel < 18) rop = {1'b1, 1'($urandom), 3'(sel - 10)};
      else rop = {1'b0, (sel == 18) ? 4'b1111 : 4'b1001};
      ra = pick_operand();
      rb = pick_operand();
      do_op("random", rop, ra, rb, $urandom_range(0, 2), 1'b0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
